lsu: RTL

- Load/store unit between the execute stage and the data-memory port.
- Consumes the effective address computed for LB/LH/LW/LBU/LHU/SB/SH/SW and the rs2 store data.
- Runs one word-addressed request/ack transaction per instruction, steering byte lanes for stores and aligning plus sign/zero-extending load data.
- Holds the pipeline via req_ready until the response pulse.

---
 rtl/lsu_pkg.sv | 50 +++++
 rtl/lsu_align.sv | 58 +++++
 rtl/lsu.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   - RV32 load/store opcodes and funct3 size/sign codes
//   - FSM state encoding
//   - helpers for legality, misalignment and effective lane selection
package lsu_pkg;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic is_legal(input logic [6:0] op, input logic [2:0] f3);
    logic ok;
    ok = 1'b0;
    if (op == OPC_LOAD)
      ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
    else if (op == OPC_STORE)
      ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return ok;
  endfunction

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    logic mis;
    mis = 1'b0;
    if ((f3 == F3_H) || (f3 == F3_HU)) mis = lo[0];
    else if (f3 == F3_W)               mis = (lo != 2'b00);
    return mis;
  endfunction

  // Low address bits that actually select the lane: halves ignore bit 0,
  // words ignore both bits.
  function automatic logic [1:0] eff_lane(input logic [2:0] f3, input logic [1:0] lo);
    logic [1:0] l;
    l = lo;
    if ((f3 == F3_H) || (f3 == F3_HU)) l = {lo[1], 1'b0};
    else if (f3 == F3_W)               l = 2'b00;
    return l;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational byte-lane logic for the load/store unit.
//   funct3     in  3   access size/sign
//   lane       in  2   effective byte offset within the word
//   store_data in  32  rs2 store data
//   rdata      in  32  word returned by memory
//   wstrb      out 4   byte write enables for the store
//   wdata      out 32  lane-replicated store data
//   load_data  out 32  extracted and sign/zero-extended load value
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [31:0] shifted;

  always_comb begin
    wstrb = 4'b0000;
    wdata = 32'h0;
    case (funct3)
      F3_B: begin
        wstrb = 4'b0001 << lane;
        wdata = {4{store_data[7:0]}};
      end
      F3_H: begin
        wstrb = 4'b0011 << {lane[1], 1'b0};
        wdata = {2{store_data[15:0]}};
      end
      F3_W: begin
        wstrb = 4'b1111;
        wdata = store_data;
      end
      default: ;
    endcase
  end

  // Move the addressed byte/half down to bit 0 before extending.
  assign shifted = rdata >> {lane, 3'b000};

  always_comb begin
    load_data = 32'h0;
    case (funct3)
      F3_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
      F3_W:    load_data = rdata;
      F3_BU:   load_data = {24'h0, shifted[7:0]};
      F3_HU:   load_data = {16'h0, shifted[15:0]};
      default: load_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// lsu: load/store unit between execute and a word-addressed memory port.
// Runs one request/ack transaction per LB/LH/LW/LBU/LHU/SB/SH/SW and
// returns a one-cycle response pulse; req_ready is high only when idle.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (misaligned half/word
// accesses respond with an error instead of clearing the low bits).
//   clock, reset          clock and asynchronous active-high reset
//   req_valid/req_ready   request handshake from execute
//   opcode, funct3        instruction kind and access size/sign
//   addr, wdata           effective byte address and rs2 store data
//   resp_valid/data/err   completion pulse, load result, error flag
//   mem_req/we/addr       memory request, held until mem_ack
//   mem_wstrb/mem_wdata   store byte enables and replicated data
//   mem_ack/mem_rdata     memory completion and read word
module lsu
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        resp_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

  state_t      state, state_nx;
  logic [31:0] tmo_cnt;
  logic [2:0]  lat_f3;
  logic [1:0]  lat_lane;
  logic        lat_load;

  logic        go_mem, trap, is_store;
  logic [1:0]  in_lane, al_lane;
  logic [2:0]  al_f3;
  logic [3:0]  wstrb_c;
  logic [31:0] wdata_c, load_c;
  logic        tmo_hit;

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap = is_misaligned(funct3, addr[1:0]);
`else
  assign trap = 1'b0;
`endif

  assign go_mem   = is_legal(opcode, funct3) && !trap;
  assign is_store = (opcode == OPC_STORE);
  assign in_lane  = eff_lane(funct3, addr[1:0]);

  // The single align instance serves store steering at accept time and
  // load extraction at ack time, so its selectors follow the state.
  assign al_f3   = (state == IDLE) ? funct3  : lat_f3;
  assign al_lane = (state == IDLE) ? in_lane : lat_lane;

  lsu_align u_align (
    .funct3     (al_f3),
    .lane       (al_lane),
    .store_data (wdata),
    .rdata      (mem_rdata),
    .wstrb      (wstrb_c),
    .wdata      (wdata_c),
    .load_data  (load_c)
  );

  assign tmo_hit = (TIMEOUT_CYCLES != 0) && (tmo_cnt == TMO_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req_valid) state_nx = go_mem ? REQ : RESP;
      REQ:     if (mem_ack || tmo_hit) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tmo_cnt   <= 32'h0;
      lat_f3    <= 3'h0;
      lat_lane  <= 2'h0;
      lat_load  <= 1'b0;
      resp_data <= 32'h0;
      resp_err  <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0;
      mem_wstrb <= 4'h0;
      mem_wdata <= 32'h0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          lat_f3   <= funct3;
          lat_lane <= in_lane;
          lat_load <= (opcode == OPC_LOAD);
          tmo_cnt  <= 32'h0;
          if (go_mem) begin
            mem_req   <= 1'b1;
            mem_we    <= is_store;
            mem_addr  <= {addr[31:2], 2'b00};
            mem_wstrb <= is_store ? wstrb_c : 4'h0;
            mem_wdata <= is_store ? wdata_c : 32'h0;
          end else begin
            resp_err  <= 1'b1;
            resp_data <= 32'h0;
          end
        end
        REQ: begin
          // Ack takes priority over a timeout expiring in the same cycle.
          if (mem_ack || tmo_hit) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'h0;
            mem_wstrb <= 4'h0;
            mem_wdata <= 32'h0;
            resp_err  <= !mem_ack;
            resp_data <= (mem_ack && lat_load) ? load_c : 32'h0;
          end else begin
            tmo_cnt <= tmo_cnt + 32'd1;
          end
        end
        RESP: begin
          resp_err  <= 1'b0;
          resp_data <= 32'h0;
        end
        default: ;
      endcase
    end
  end

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);

endmodule
